pdm_capture_pipeline: RTL and testbench

// Multi-channel PDM-to-PCM capture pipeline for the Audio Capture Unit: per-channel CIC decimation,

---
 rtl/pdm_capture_pipeline.sv | 232 +++++++++++++++++++++++
 tb/tb_pdm_capture_pipeline.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture_pipeline.sv
// Multi-channel PDM-to-PCM capture: per-channel CIC decimator, shift normalisation,
// Q1.15 gain with saturation, and a first-word-fall-through output FIFO.
module pdm_capture_pipeline #(
  parameter int CHANNELS   = 2,
  parameter int CIC_ORDER  = 3,
  parameter int CIC_DELAY  = 1,
  parameter int ACC_WIDTH  = 32,
  parameter int PCM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clk_en_i,
  input  logic                 pdm_i,
  input  logic                 pdm_valid_i,
  input  logic [CH_W-1:0]      pdm_channel_i,
  input  logic [6:0]           decimation_i,
  input  logic [4:0]           norm_shift_i,
  input  logic [15:0]          gain_i,
  output logic [PCM_WIDTH-1:0] pcm_o,
  output logic [CH_W-1:0]      pcm_channel_o,
  output logic                 pcm_valid_o,
  input  logic                 pcm_ready_i,
  output logic [CNT_W-1:0]     fifo_count_o,
  output logic                 overflow_o,
  input  logic                 clear_overflow_i
);

  localparam int AW     = CNT_W - 1;
  localparam int PROD_W = PCM_WIDTH + 16;
  localparam logic signed [PCM_WIDTH-1:0] P_MAX = {1'b0, {(PCM_WIDTH-1){1'b1}}};
  localparam logic signed [PCM_WIDTH-1:0] P_MIN = {1'b1, {(PCM_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'(P_MAX);
  localparam logic signed [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(P_MIN);
  localparam logic signed [PROD_W-1:0]    G_MAX = PROD_W'(P_MAX);
  localparam logic signed [PROD_W-1:0]    G_MIN = PROD_W'(P_MIN);
  localparam logic signed [PROD_W-1:0]    RND   = PROD_W'(16384);

  // Per-channel filter state; channels are selected by tag compare so no state is shared.
  logic [CIC_ORDER-1:0][ACC_WIDTH-1:0]                r_integ [CHANNELS];
  logic [6:0]                                         r_cnt   [CHANNELS];
  logic [CIC_ORDER-1:0][CIC_DELAY-1:0][ACC_WIDTH-1:0] r_hist  [CHANNELS];

  logic                        r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
  logic [ACC_WIDTH-1:0]        r_s1_data, r_s2_data;
  logic signed [PCM_WIDTH-1:0] r_s3_data, r_s4_data;
  logic [CH_W-1:0]             r_s1_ch, r_s2_ch, r_s3_ch, r_s4_ch;

  logic                                w_hit, w_dec_done;
  logic [6:0]                          w_cnt_cur, w_r;
  logic [CIC_ORDER-1:0][ACC_WIDTH-1:0] w_integ_cur, w_integ_nxt;

  always_comb begin
    w_hit       = 1'b0;
    w_integ_cur = '0;
    w_cnt_cur   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (pdm_channel_i == CH_W'(c)) begin
        w_hit       = pdm_valid_i & clk_en_i;
        w_integ_cur = r_integ[c];
        w_cnt_cur   = r_cnt[c];
      end
    end
    w_integ_nxt[0] = w_integ_cur[0] + (pdm_i ? ACC_WIDTH'(1) : {ACC_WIDTH{1'b1}});
    for (int k = 1; k < CIC_ORDER; k++) begin
      w_integ_nxt[k] = w_integ_cur[k] + w_integ_nxt[k-1];
    end
    w_r        = (decimation_i < 7'd2) ? 7'd2 : decimation_i;
    w_dec_done = (w_cnt_cur >= w_r - 7'd1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_integ[c] <= '0;
        r_cnt[c]   <= '0;
      end
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_ch    <= '0;
    end else if (!clk_en_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_integ[c] <= '0;
        r_cnt[c]   <= '0;
      end
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_hit & w_dec_done;
      if (w_hit & w_dec_done) begin
        r_s1_data <= w_integ_nxt[CIC_ORDER-1];
        r_s1_ch   <= pdm_channel_i;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_hit && (pdm_channel_i == CH_W'(c))) begin
          r_integ[c] <= w_integ_nxt;
          r_cnt[c]   <= w_dec_done ? 7'd0 : w_cnt_cur + 7'd1;
        end
      end
    end
  end

  logic [CIC_ORDER-1:0][CIC_DELAY-1:0][ACC_WIDTH-1:0] w_hist_cur;
  logic [CIC_ORDER-1:0][ACC_WIDTH-1:0]                w_comb_in;
  logic [ACC_WIDTH-1:0]                               w_comb_v;

  always_comb begin
    w_hist_cur = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_s1_ch == CH_W'(c)) w_hist_cur = r_hist[c];
    end
    w_comb_v = r_s1_data;
    for (int k = 0; k < CIC_ORDER; k++) begin
      w_comb_in[k] = w_comb_v;
      w_comb_v     = w_comb_v - w_hist_cur[k][CIC_DELAY-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int c = 0; c < CHANNELS; c++) r_hist[c] <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_ch    <= '0;
    end else if (!clk_en_i) begin
      for (int c = 0; c < CHANNELS; c++) r_hist[c] <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_comb_v;
        r_s2_ch   <= r_s1_ch;
        for (int c = 0; c < CHANNELS; c++) begin
          if (r_s1_ch == CH_W'(c)) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
              r_hist[c][k][0] <= w_comb_in[k];
              for (int j = 1; j < CIC_DELAY; j++) r_hist[c][k][j] <= r_hist[c][k][j-1];
            end
          end
        end
      end
    end
  end

  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic signed [PCM_WIDTH-1:0] w_norm, w_gained;
  logic signed [PROD_W-1:0]    w_prod, w_round;

  always_comb begin
    w_shifted = $signed(r_s2_data) >>> norm_shift_i;
    if (w_shifted > S_MAX)      w_norm = P_MAX;
    else if (w_shifted < S_MIN) w_norm = P_MIN;
    else                        w_norm = w_shifted[PCM_WIDTH-1:0];
    // Round half up in Q1.15, then clamp (only -1.0 * most-negative can exceed range).
    w_prod  = r_s3_data * $signed(gain_i);
    w_round = (w_prod + RND) >>> 15;
    if (w_round > G_MAX)      w_gained = P_MAX;
    else if (w_round < G_MIN) w_gained = P_MIN;
    else                      w_gained = w_round[PCM_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s3_valid <= 1'b0;
      r_s3_data  <= '0;
      r_s3_ch    <= '0;
      r_s4_valid <= 1'b0;
      r_s4_data  <= '0;
      r_s4_ch    <= '0;
    end else if (!clk_en_i) begin
      r_s3_valid <= 1'b0;
      r_s4_valid <= 1'b0;
    end else begin
      r_s3_valid <= r_s2_valid;
      r_s4_valid <= r_s3_valid;
      if (r_s2_valid) begin
        r_s3_data <= w_norm;
        r_s3_ch   <= r_s2_ch;
      end
      if (r_s3_valid) begin
        r_s4_data <= w_gained;
        r_s4_ch   <= r_s3_ch;
      end
    end
  end

  // Handshake: pcm_valid_o is high whenever the FIFO holds a sample; the head is consumed
  // on any rising clock edge where pcm_valid_o && pcm_ready_i. Data stays stable until then.
  logic [PCM_WIDTH-1:0] r_mem    [FIFO_DEPTH];
  logic [CH_W-1:0]      r_mem_ch [FIFO_DEPTH];
  logic [AW:0]          r_wr, r_rd;
  logic                 r_overflow;
  logic [CNT_W-1:0]     w_count;
  logic                 w_empty, w_full, w_pop, w_push, w_drop;

  always_comb begin
    w_count = r_wr - r_rd;
    w_empty = (w_count == '0);
    w_full  = (w_count == CNT_W'(FIFO_DEPTH));
    w_pop   = !w_empty && pcm_ready_i;
    w_push  = r_s4_valid && (!w_full || w_pop);
    w_drop  = r_s4_valid && w_full && !w_pop;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]]    <= r_s4_data;
      r_mem_ch[r_wr[AW-1:0]] <= r_s4_ch;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_drop)                r_overflow <= 1'b1;
      else if (clear_overflow_i) r_overflow <= 1'b0;
    end
  end

  assign pcm_valid_o   = !w_empty;
  assign pcm_o         = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
  assign pcm_channel_o = w_empty ? '0 : r_mem_ch[r_rd[AW-1:0]];
  assign fifo_count_o  = w_count;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_pdm_capture_pipeline.sv
// Bench for pdm_capture_pipeline: directed and random PDM streams against an FIR-equivalent
// CIC reference model, with a queue scoreboard drained by an output monitor.
module tb_pdm_capture_pipeline;
  localparam int CHANNELS   = 3;
  localparam int CIC_ORDER  = 3;
  localparam int CIC_DELAY  = 1;
  localparam int ACC_WIDTH  = 32;
  localparam int PCM_WIDTH  = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CH_W       = 2;
  localparam int CNT_W      = 4;
  localparam int PW         = PCM_WIDTH;
  localparam int EW         = 1 + CH_W + PW;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             clk_en_i = 1'b0;
  logic             pdm_i = 1'b0;
  logic             pdm_valid_i = 1'b0;
  logic [CH_W-1:0]  pdm_channel_i = '0;
  logic [6:0]       decimation_i = 7'd16;
  logic [4:0]       norm_shift_i = '0;
  logic [15:0]      gain_i = 16'h7FFF;
  logic [PW-1:0]    pcm_o;
  logic [CH_W-1:0]  pcm_channel_o;
  logic             pcm_valid_o;
  logic             pcm_ready_i = 1'b1;
  logic [CNT_W-1:0] fifo_count_o;
  logic             overflow_o;
  logic             clear_overflow_i = 1'b0;

  pdm_capture_pipeline #(
    .CHANNELS(CHANNELS), .CIC_ORDER(CIC_ORDER), .CIC_DELAY(CIC_DELAY),
    .ACC_WIDTH(ACC_WIDTH), .PCM_WIDTH(PCM_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .pdm_i(pdm_i),
    .pdm_valid_i(pdm_valid_i), .pdm_channel_i(pdm_channel_i), .decimation_i(decimation_i),
    .norm_shift_i(norm_shift_i), .gain_i(gain_i), .pcm_o(pcm_o), .pcm_channel_o(pcm_channel_o),
    .pcm_valid_o(pcm_valid_o), .pcm_ready_i(pcm_ready_i), .fifo_count_o(fifo_count_o),
    .overflow_o(overflow_o), .clear_overflow_i(clear_overflow_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int             checks = 0;
  int             failures = 0;
  logic [EW-1:0]  exp_q[$];
  int             exp_t[$];
  longint         h_q[$];
  int             xh[CHANNELS][$];
  int             dcnt[CHANNELS];
  int             nout[CHANNELS];
  bit             lat_chk = 1'b0;
  bit             rand_ready = 1'b0;

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // CIC response as an FIR: N-fold convolution of a length R*M boxcar.
  task automatic build_h(int r);
    longint t[$];
    longint s;
    int     len;
    len = r * CIC_DELAY;
    h_q = {64'sd1};
    repeat (CIC_ORDER) begin
      t = {};
      for (int i = 0; i < h_q.size() + len - 1; i++) begin
        s = 0;
        for (int j = 0; j < len; j++)
          if ((i - j >= 0) && (i - j < h_q.size())) s += h_q[i-j];
        t.push_back(s);
      end
      h_q = t;
    end
  endtask

  function automatic longint clamp(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [PW-1:0] model_pcm(longint acc);
    logic [31:0] a32;
    longint      y, p, r;
    a32 = acc[31:0];
    y   = longint'($signed(a32));
    y   = clamp(y >>> norm_shift_i);
    p   = y * longint'($signed(gain_i));
    r   = clamp((p + 16384) >>> 15);
    return r[PW-1:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++) begin
      xh[c].delete();
      dcnt[c] = 0;
      nout[c] = 0;
    end
  endtask

  task automatic model_in(int ch, bit b, int t);
    int     r;
    longint acc;
    logic   chk;
    if (ch >= CHANNELS) return;
    r = (decimation_i < 2) ? 2 : int'(decimation_i);
    xh[ch].push_back(b ? 1 : -1);
    if (xh[ch].size() > h_q.size()) void'(xh[ch].pop_front());
    dcnt[ch]++;
    if (dcnt[ch] == r) begin
      dcnt[ch] = 0;
      acc = 0;
      for (int k = 0; k < h_q.size() && k < xh[ch].size(); k++)
        acc += h_q[k] * longint'(xh[ch][xh[ch].size()-1-k]);
      chk = (nout[ch] >= CIC_ORDER * CIC_DELAY);
      exp_q.push_back({chk, CH_W'(ch), model_pcm(acc)});
      exp_t.push_back(lat_chk ? t : -1);
      nout[ch]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (rand_ready) pcm_ready_i = ($urandom_range(0, 3) != 0) || (fifo_count_o >= 4);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(int ch, bit b);
    pdm_valid_i   = 1'b1;
    pdm_channel_i = CH_W'(ch);
    pdm_i         = b;
    tick();
    pdm_valid_i   = 1'b0;
    if (clk_en_i) model_in(ch, b, cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pcm_valid_o) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain_timeout: %0d expected samples never appeared", exp_q.size());
    end
  endtask

  task automatic reconfig(int dec, int sh, int g);
    drain();
    clk_en_i = 1'b0;
    tick();
    tick();
    decimation_i = 7'(dec);
    norm_shift_i = 5'(sh);
    gain_i       = 16'(g);
    build_h((dec < 2) ? 2 : dec);
    model_clear();
    clk_en_i = 1'b1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_pcm"}, pcm_o, 0);
    check({tag, "_ch"}, pcm_channel_o, 0);
    check({tag, "_valid"}, pcm_valid_o, 0);
    check({tag, "_count"}, fifo_count_o, 0);
    check({tag, "_overflow"}, overflow_o, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    int            t;
    if (rst_n_i && pcm_valid_o && pcm_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: ch %0d value %0d, none expected", pcm_channel_o, $signed(pcm_o));
      end else begin
        e = exp_q.pop_front();
        t = exp_t.pop_front();
        check("pcm_channel", pcm_channel_o, e[PW+CH_W-1:PW]);
        if (e[EW-1]) check("pcm_value", $signed(pcm_o), $signed(e[PW-1:0]));
        if (t >= 0) check("latency", cyc - t, 4);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_n_i = 1'b1;
    tick();

    // Constant +1 on one channel, unity gain: settled 4096, 4-cycle latency.
    reconfig(16, 0, 16'h7FFF);
    lat_chk = 1'b1;
    repeat (16 * 8) drive(0, 1'b1);
    drain();
    lat_chk = 1'b0;

    // Constant -1, half gain, negative unity gain.
    reconfig(16, 0, 16'h7FFF);
    repeat (16 * 8) drive(0, 1'b0);
    reconfig(16, 0, 16'h4000);
    repeat (16 * 8) drive(0, 1'b1);
    reconfig(16, 0, 16'h8000);
    repeat (16 * 8) drive(0, 1'b1);

    // Large decimation: normaliser saturation, then in-range shift.
    reconfig(64, 2, 16'h7FFF);
    repeat (64 * 7) drive(0, 1'b1);
    reconfig(64, 4, 16'h7FFF);
    repeat (64 * 7) drive(0, 1'b1);

    // Two interleaved channels with opposite constant input.
    reconfig(16, 0, 16'h7FFF);
    repeat (16 * 6) begin
      drive(0, 1'b1);
      drive(1, 1'b0);
    end

    // Back-pressure: 10 outputs into an 8-deep FIFO, last two dropped.
    reconfig(16, 0, 16'h7FFF);
    pcm_ready_i = 1'b0;
    repeat (16 * 10) drive(0, 1'b1);
    repeat (8) tick();
    check("full_count", fifo_count_o, FIFO_DEPTH);
    check("full_overflow", overflow_o, 1);
    check("full_valid", pcm_valid_o, 1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_t.pop_back());
    void'(exp_t.pop_back());
    clear_overflow_i = 1'b1;
    tick();
    clear_overflow_i = 1'b0;
    check("overflow_cleared", overflow_o, 0);
    check("count_after_clear", fifo_count_o, FIFO_DEPTH);
    clk_en_i    = 1'b0;
    pcm_ready_i = 1'b1;
    drain();
    check("drained_count", fifo_count_o, 0);
    check("drained_valid", pcm_valid_o, 0);

    // Random streams: random R (0/1 mean 2), shift, gain, channel (3 is ignored), ready.
    for (int rnd = 0; rnd < 6; rnd++) begin
      reconfig($urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(0, 65535));
      rand_ready = 1'b1;
      repeat (250) begin
        if ($urandom_range(0, 4) == 0) tick();
        else drive($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset in the middle of a stream.
    reconfig(8, 0, 16'h7FFF);
    repeat (60) drive($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    #3 rst_n_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_t.delete();
    model_clear();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    repeat (150) drive($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    drain();
    rand_ready  = 1'b0;
    pcm_ready_i = 1'b1;
    repeat (6) tick();
    check("final_count", fifo_count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
